// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding,
// operand/product widths, operand payload struct and a round-robin helper.
package mul_share_arbiter_pkg;

  localparam int unsigned OPND_W  = 8;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned DONE_W  = 16;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP   = 2'd2;

  // Operand pair presented to the shared multiplier.
  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } mul_operands_t;

  // Next round-robin pointer: one past idx, wrapping at n.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Bus bundle for the multiplier-sharing arbiter.
//   req_*  : per-requester valid/ready request channel, operands packed 8 bits per requester
//   mul_*  : operand/product connection to the external shared multiplier
//   rsp_*  : single valid/ready response channel carrying requester id and product
// slave  = arbiter view, master = clients/multiplier view.
interface mul_share_arbiter_if
  import mul_share_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*OPND_W-1:0] req_a;
  logic [N_REQ*OPND_W-1:0] req_b;
  logic [N_REQ-1:0]        req_ready;

  logic [OPND_W-1:0]       mul_a;
  logic [OPND_W-1:0]       mul_b;
  logic [PROD_W-1:0]       mul_p;

  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [PROD_W-1:0]       rsp_product;
  logic                    rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_product
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_product
  );

endinterface

// File: rtl/mul_share_arbiter_rr_priority_picker.sv
// Combinational round-robin priority picker.
//   req       : request vector
//   ptr       : highest-priority index for this pick
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : binary index of the granted request
//   any       : at least one request is set
module rr_priority_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Walk from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      if (req[(32'(ptr) + k - 32'd1) % N_REQ]) begin
        grant_idx = IDX_W'((32'(ptr) + k - 32'd1) % N_REQ);
        any       = 1'b1;
      end
    end
    if (any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one external combinational 8x8 multiplier between N_REQ requesters.
// Round-robin grants a request, registers its operands onto the multiplier,
// waits SETTLE_CYCLES for the array to settle, captures the product and
// returns it with the requester id on a valid/ready response channel.
//   clk, rst_n : clock, async active-low reset
//   bus        : request / multiplier / response bundle (slave view)
//   busy       : FSM is not in IDLE
//   done_count : completed transactions, wrapping
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_share_arbiter_if.slave   bus,
  output logic                 busy,
  output logic [DONE_W-1:0]    done_count
);

  localparam int unsigned      CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic               accept_c, capture_c, rsp_fire_c;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  logic [ID_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]   settle_cnt_q;
  mul_operands_t      opnd_sel, opnd_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [PROD_W-1:0]  rsp_product_q;
  logic               rsp_valid_q;
  logic               busy_q;
  logic [DONE_W-1:0]  done_count_q;

  // Round-robin pick among the currently valid requesters.
  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_picker (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Operands of the granted requester.
  assign opnd_sel.a = bus.req_a[32'(grant_idx)*OPND_W +: OPND_W];
  assign opnd_sel.b = bus.req_b[32'(grant_idx)*OPND_W +: OPND_W];

  // Accept strobe only offered in IDLE and never while reset is held.
  assign bus.req_ready = (rst_n && (state_q == ST_IDLE)) ? grant : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and transaction strobes.
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    capture_c  = 1'b0;
    rsp_fire_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          accept_c = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          capture_c = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_fire_c = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers driven by the FSM strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      settle_cnt_q  <= '0;
      opnd_q        <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_count_q  <= '0;
    end else begin
      if (accept_c) begin
        opnd_q       <= opnd_sel;
        rsp_id_q     <= grant_idx;
        rr_ptr_q     <= ID_W'(rr_wrap_inc(32'(grant_idx), N_REQ));
        settle_cnt_q <= CNT_LOAD;
      end else if ((state_q == ST_SETTLE) && (settle_cnt_q != '0)) begin
        settle_cnt_q <= settle_cnt_q - CNT_W'(1);
      end
      if (capture_c) begin
        rsp_product_q <= bus.mul_p;
      end
      rsp_valid_q <= (state_d == ST_RESP);
      busy_q      <= (state_d != ST_IDLE);
      if (rsp_fire_c) begin
        done_count_q <= done_count_q + DONE_W'(1);
      end
    end
  end

  assign bus.mul_a       = opnd_q.a;
  assign bus.mul_b       = opnd_q.b;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;
  assign busy            = busy_q;
  assign done_count      = done_count_q;

endmodule
